// File: rtl/dct2_pkg.sv
// Shared definitions for the 2D DCT-II transpose datapath: sequencing states,
// block-size limits and the block-size clamp.
package dct2_pkg;

    localparam int MIN_LOG2 = 2;
    localparam int MAX_N    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } tb_state_e;

    // Requested sizes outside [MIN_LOG2, max_log2] are pinned to the nearest supported size.
    function automatic logic [2:0] clamp_size_log2(input logic [2:0] size_log2,
                                                    input int         max_log2);
        if (int'(size_log2) < MIN_LOG2) begin
            return 3'(MIN_LOG2);
        end
        if (int'(size_log2) > max_log2) begin
            return 3'(max_log2);
        end
        return size_log2;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Row/column beat counter with synchronous clear, increment and a terminal-count
// flag against the latched last index (n-1).
module beat_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] last_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign at_last_o = (count_q == last_val_i);

endmodule

// File: rtl/transpose_buffer_ctrl.sv
// Fill/drain sequencer for the N x N transpose buffer: rows shift in on direction 0,
// columns shift out on direction 1, each side gated by its own valid/ready handshake.
module transpose_buffer_ctrl
    import dct2_pkg::*;
#(
    parameter int MAX_N = dct2_pkg::MAX_N,
    parameter int CNT_W = $clog2(MAX_N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       size_log2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             buf_enable,
    output logic             buf_direction,
    output logic [CNT_W-1:0] beat_idx,
    output logic             busy,
    output logic             block_done
);

    localparam int               MAX_LOG2 = $clog2(MAX_N);
    localparam logic [CNT_W-1:0] ONES     = '1;

    // Handshake: a beat transfers on any cycle where valid and ready are both high
    // on that side; enable to the cells is exactly that transfer condition.
    tb_state_e        state_q, state_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             at_last;

    beat_counter #(
        .CNT_W(CNT_W)
    ) u_beat_counter (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (cnt_clr),
        .inc_i      (cnt_inc),
        .last_val_i (last_q),
        .count_o    (cnt),
        .at_last_o  (at_last)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // n-1 is the low clamp(size_log2) bits set.
                    last_d  = ~(ONES << clamp_size_log2(size_log2, MAX_LOG2));
                    cnt_clr = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    if (at_last) begin
                        cnt_clr = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (at_last) begin
                        cnt_clr = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= CNT_W'(3);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign in_ready      = (state_q == ST_FILL);
    assign out_valid     = (state_q == ST_DRAIN);
    assign buf_direction = (state_q == ST_DRAIN);
    assign busy          = (state_q != ST_IDLE);
    assign out_last      = (state_q == ST_DRAIN) && at_last;
    assign buf_enable    = ((state_q == ST_FILL) && in_valid) || ((state_q == ST_DRAIN) && out_ready);
    assign beat_idx      = cnt;
    assign block_done    = done_q;

endmodule

// File: tb/tb_transpose_buffer_ctrl.sv
// Directed bench for transpose_buffer_ctrl: a table of block configurations run
// back to back, plus hand-written mid-block reset and stall sequences.
module tb_transpose_buffer_ctrl;

    localparam int MAX_N = 32;
    localparam int CNT_W = 5;

    logic             clock;
    logic             reset;
    logic             start;
    logic [2:0]       size_log2;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             buf_enable;
    logic             buf_direction;
    logic [CNT_W-1:0] beat_idx;
    logic             busy;
    logic             block_done;

    transpose_buffer_ctrl #(
        .MAX_N(MAX_N),
        .CNT_W(CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .size_log2     (size_log2),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .buf_enable    (buf_enable),
        .buf_direction (buf_direction),
        .beat_idx      (beat_idx),
        .busy          (busy),
        .block_done    (block_done)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the controller (0 = idle, 1 = fill, 2 = drain).
    int m_state = 0;
    int m_cnt   = 0;
    int m_n     = 4;
    int m_done  = 0;

    typedef struct {
        logic [2:0] sz;
        int         exp_n;
        bit         toggle;
        bit         stall;
        bit         noise;
        int         idle_after;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[7];

    function automatic int ref_n(input logic [2:0] sz);
        if (sz < 3'd2) return 4;
        if (sz > 3'd5) return MAX_N;
        return 1 << sz;
    endfunction

    function automatic logic [11:0] pack_outputs();
        return {in_ready, out_valid, out_last, buf_enable, buf_direction, busy, block_done, beat_idx};
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_check(input logic s, input logic [2:0] sz, input logic iv, input logic ordy);
        logic [11:0] exp_v;
        logic [11:0] act_v;
        start     = s;
        size_log2 = sz;
        in_valid  = iv;
        out_ready = ordy;
        #1;
        exp_v = {m_state == 1, m_state == 2, (m_state == 2) && (m_cnt == m_n - 1),
                 ((m_state == 1) && iv) || ((m_state == 2) && ordy),
                 m_state == 2, m_state != 0, m_done != 0, 5'(m_cnt)};
        act_v = pack_outputs();
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs @%0t: got %03h expected %03h (rdy,vld,last,en,dir,busy,done,idx)",
                     $time, act_v, exp_v);
        end
    endtask

    task automatic tick();
        int nxt_done;
        @(posedge clock);
        nxt_done = 0;
        case (m_state)
            0: if (start) begin
                m_n     = ref_n(size_log2);
                m_cnt   = 0;
                m_state = 1;
            end
            1: if (in_valid) begin
                if (m_cnt == m_n - 1) begin
                    m_cnt   = 0;
                    m_state = 2;
                end else begin
                    m_cnt++;
                end
            end
            default: if (out_ready) begin
                if (m_cnt == m_n - 1) begin
                    m_cnt    = 0;
                    m_state  = 0;
                    nxt_done = 1;
                end else begin
                    m_cnt++;
                end
            end
        endcase
        m_done = nxt_done;
        @(negedge clock);
    endtask

    // Starts a block in the current cycle and returns in the cycle where block_done is high.
    task automatic run_block(input vec_t v, input int idx);
        int       fill_en   = 0;
        int       drain_en  = 0;
        int       stall_left = v.stall ? 5 : 0;
        int       k;
        bit       done_seen = 0;
        logic     iv, ordy;
        drive_check(1'b1, v.sz, 1'b1, 1'b1);
        tick();
        for (k = 1; k < 400; k++) begin
            if (m_done != 0) begin
                drive_check(1'b0, 3'd0, 1'b1, 1'b1);
                done_seen = 1;
                break;
            end
            iv   = v.toggle ? k[0] : 1'b1;
            ordy = 1'b1;
            if (v.stall && m_state == 2 && m_cnt == 10 && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            drive_check(v.noise, v.noise ? 3'd5 : v.sz, iv, ordy);
            if (!ordy) check_int($sformatf("stall_idx[%0d]", idx), int'(beat_idx), 10);
            if (buf_enable && !buf_direction) fill_en++;
            if (buf_enable && buf_direction) drain_en++;
            tick();
        end
        if (!done_seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout[%0d]: no block_done within 400 cycles", idx);
        end
        check_int($sformatf("fill_beats[%0d]", idx), fill_en, v.exp_n);
        check_int($sformatf("drain_beats[%0d]", idx), drain_en, v.exp_n);
        check_int($sformatf("start_to_done[%0d]", idx), k, v.exp_cycles);
    endtask

    // ---------------- stimulus + report ----------------
    initial begin
        vec_t v;
        int   guard;
        vecs[0] = '{sz: 3'd3, exp_n: 8,  toggle: 0, stall: 0, noise: 0, idle_after: 0, exp_cycles: 17};
        vecs[1] = '{sz: 3'd2, exp_n: 4,  toggle: 0, stall: 0, noise: 0, idle_after: 2, exp_cycles: 9};
        vecs[2] = '{sz: 3'd0, exp_n: 4,  toggle: 0, stall: 0, noise: 1, idle_after: 0, exp_cycles: 9};
        vecs[3] = '{sz: 3'd7, exp_n: 32, toggle: 0, stall: 0, noise: 0, idle_after: 1, exp_cycles: 65};
        vecs[4] = '{sz: 3'd5, exp_n: 32, toggle: 1, stall: 1, noise: 0, idle_after: 0, exp_cycles: 101};
        vecs[5] = '{sz: 3'd1, exp_n: 4,  toggle: 0, stall: 0, noise: 0, idle_after: 3, exp_cycles: 9};
        vecs[6] = '{sz: 3'd4, exp_n: 16, toggle: 0, stall: 0, noise: 1, idle_after: 0, exp_cycles: 33};

        reset     = 1'b1;
        start     = 1'b0;
        size_log2 = 3'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_int("reset_outputs", int'(pack_outputs()), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_block(vecs[i], i);
            repeat (vecs[i].idle_after) begin
                tick();
                drive_check(1'b0, 3'd0, 1'b1, 1'b1);
            end
        end

        // Mid-FILL reset at beat 2, then a clean 4+4 block.
        tick();
        drive_check(1'b1, 3'd3, 1'b1, 1'b1);
        tick();
        guard = 0;
        while (m_cnt != 2 && guard < 20) begin
            drive_check(1'b0, 3'd0, 1'b1, 1'b1);
            tick();
            guard++;
        end
        drive_check(1'b0, 3'd0, 1'b1, 1'b1);
        check_int("pre_reset_enable", int'(buf_enable), 1);
        reset = 1'b1;
        #1;
        check_int("mid_reset_outputs", int'(pack_outputs()), 0);
        m_state = 0;
        m_cnt   = 0;
        m_n     = 4;
        m_done  = 0;
        @(negedge clock);
        reset = 1'b0;
        v = '{sz: 3'd2, exp_n: 4, toggle: 0, stall: 0, noise: 0, idle_after: 0, exp_cycles: 9};
        run_block(v, 7);
        tick();
        drive_check(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
